mem_access_ctrl: RTL and testbench

- MEM-stage data-access controller. Consumes the EX/MEM pipeline register outputs (load/store control, width, signedness, physical address, store data).
- Drives an SRAM-like data bus: split request/address handshake and data handshake.
- Returns an aligned, extended load result toward MEM/WB. Stalls the pipeline while a transaction is outstanding.
- Flags address-error exceptions (AdEL/AdES) before any bus request is issued.

---
 rtl/mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-access controller: issues SRAM-like bus transactions for loads/stores,
// formats store lanes and load results, stalls the pipeline while a transaction is open.
module mem_access_ctrl #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemToRegM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemWidthM,
  input  logic        LoadUnsignedM,
  input  logic [31:0] PhyAddrM,
  input  logic [31:0] WriteDataM,
  input  logic        ExcValidM,
  input  logic        FlushM,
  input  logic        PipeEnM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        AdELM,
  output logic        AdESM
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state, stateNext;
  logic            cancel, cancelNext;
  logic            killed;

  logic            latLoad, latWr, latUns;
  logic [1:0]      latSize;
  logic [DW-1:0]   latAddr, latWdata;
  logic [SW-1:0]   latWstrb;

  logic            mis, av;
  logic [SW-1:0]   inWstrb;
  logic [DW-1:0]   inWdata;

  logic            reqC, stallC, latchEn, captureEn;
  logic            busWr;
  logic [1:0]      busSize;
  logic [DW-1:0]   busAddr, busWdata;
  logic [SW-1:0]   busWstrb;

  logic [1:0]      curSize;
  logic [DW-1:0]   curAddr;
  logic            curUns;
  logic [7:0]      byteLane;
  logic [15:0]     halfLane;
  logic [DW-1:0]   loadFmt;

  // Alignment check and address-error flags
  always_comb begin
    case (MemWidthM)
      2'b00:   mis = 1'b0;
      2'b01:   mis = PhyAddrM[0];
      default: mis = |PhyAddrM[1:0];
    endcase
  end

  assign AdELM = CHECK_ALIGN & MemToRegM & mis & ~ExcValidM;
  assign AdESM = CHECK_ALIGN & MemWriteM & mis & ~ExcValidM;
  assign av    = (MemToRegM | MemWriteM) & ~(CHECK_ALIGN & mis) & ~ExcValidM & ~FlushM;

  // Store lane replication and byte enables
  always_comb begin
    inWstrb = '0;
    inWdata = WriteDataM;
    case (MemWidthM)
      2'b00: begin
        inWdata = {4{WriteDataM[7:0]}};
        inWstrb = SW'(4'b0001 << PhyAddrM[1:0]);
      end
      2'b01: begin
        inWdata = {2{WriteDataM[15:0]}};
        inWstrb = PhyAddrM[1] ? 4'b1100 : 4'b0011;
      end
      default: inWstrb = 4'b1111;
    endcase
    if (!MemWriteM) inWstrb = '0;
  end

  // Load formatting uses live inputs for single-cycle completion, the latch otherwise
  always_comb begin
    curSize = (state == IDLE) ? MemWidthM     : latSize;
    curAddr = (state == IDLE) ? PhyAddrM      : latAddr;
    curUns  = (state == IDLE) ? LoadUnsignedM : latUns;
    case (curAddr[1:0])
      2'b00:   byteLane = data_rdata[7:0];
      2'b01:   byteLane = data_rdata[15:8];
      2'b10:   byteLane = data_rdata[23:16];
      default: byteLane = data_rdata[31:24];
    endcase
    halfLane = curAddr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (curSize)
      2'b00:   loadFmt = curUns ? {24'h0, byteLane} : {{24{byteLane[7]}}, byteLane};
      2'b01:   loadFmt = curUns ? {16'h0, halfLane} : {{16{halfLane[15]}}, halfLane};
      default: loadFmt = data_rdata;
    endcase
  end

  assign killed = cancel | FlushM;

  // Next-state and handshake control
  always_comb begin
    stateNext  = state;
    cancelNext = cancel;
    reqC       = 1'b0;
    stallC     = 1'b0;
    latchEn    = 1'b0;
    captureEn  = 1'b0;
    case (state)
      IDLE: begin
        if (av) begin
          reqC    = 1'b1;
          latchEn = 1'b1;
          if (data_addr_ok && data_data_ok) begin
            stateNext = DONE;
            captureEn = MemToRegM;
          end else begin
            stallC    = 1'b1;
            stateNext = data_addr_ok ? WAIT : REQ;
          end
        end
      end
      REQ: begin
        reqC       = 1'b1;
        stallC     = 1'b1;
        cancelNext = killed;
        if (data_addr_ok) begin
          stateNext = WAIT;
          if (data_data_ok) begin
            cancelNext = 1'b0;
            stateNext  = killed ? IDLE : DONE;
            captureEn  = latLoad & ~killed;
          end
        end
      end
      WAIT: begin
        stallC     = 1'b1;
        cancelNext = killed;
        if (data_data_ok) begin
          cancelNext = 1'b0;
          stateNext  = killed ? IDLE : DONE;
          captureEn  = latLoad & ~killed;
        end
      end
      DONE: begin
        if (FlushM || PipeEnM) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bus fields: live inputs on first issue, latched copy afterwards
  always_comb begin
    if (state == IDLE) begin
      busWr    = av & MemWriteM;
      busSize  = av ? MemWidthM : 2'b00;
      busAddr  = av ? PhyAddrM  : '0;
      busWstrb = av ? inWstrb   : '0;
      busWdata = av ? inWdata   : '0;
    end else begin
      busWr    = latWr;
      busSize  = latSize;
      busAddr  = latAddr;
      busWstrb = latWstrb;
      busWdata = latWdata;
    end
  end

  assign data_req   = rst & reqC;
  assign data_wr    = rst & busWr;
  assign data_size  = rst ? busSize  : 2'b00;
  assign data_addr  = rst ? busAddr  : '0;
  assign data_wstrb = rst ? busWstrb : '0;
  assign data_wdata = rst ? busWdata : '0;
  assign MemStallM  = rst & stallC;

  // State, cancel flag, request latch and load result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cancel    <= 1'b0;
      latLoad   <= 1'b0;
      latWr     <= 1'b0;
      latUns    <= 1'b0;
      latSize   <= 2'b00;
      latAddr   <= '0;
      latWstrb  <= '0;
      latWdata  <= '0;
      ReadDataM <= '0;
    end else begin
      state  <= stateNext;
      cancel <= cancelNext;
      if (latchEn) begin
        latLoad  <= MemToRegM;
        latWr    <= MemWriteM;
        latUns   <= LoadUnsignedM;
        latSize  <= MemWidthM;
        latAddr  <= PhyAddrM;
        latWstrb <= inWstrb;
        latWdata <= inWdata;
      end
      if (captureEn) ReadDataM <= loadFmt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl; expectations come from a
// transaction-level model of latency, lane formatting and result retention.
module tb_mem_access_ctrl;

  logic        clk, rst;
  logic        MemToRegM, MemWriteM, LoadUnsignedM, ExcValidM, FlushM, PipeEnM;
  logic [1:0]  MemWidthM;
  logic [31:0] PhyAddrM, WriteDataM;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, ReadDataM;
  logic [3:0]  data_wstrb;
  logic        MemStallM, AdELM, AdESM;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] refRd = 32'h0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .MemWidthM(MemWidthM),
    .LoadUnsignedM(LoadUnsignedM), .PhyAddrM(PhyAddrM), .WriteDataM(WriteDataM),
    .ExcValidM(ExcValidM), .FlushM(FlushM), .PipeEnM(PipeEnM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ReadDataM(ReadDataM), .MemStallM(MemStallM), .AdELM(AdELM), .AdESM(AdESM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    MemToRegM = 1'b0; MemWriteM = 1'b0; MemWidthM = 2'b00; LoadUnsignedM = 1'b0;
    PhyAddrM = 32'h0; WriteDataM = 32'h0; ExcValidM = 1'b0; FlushM = 1'b0; PipeEnM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
  endtask

  function automatic logic [31:0] expLoad(input logic [1:0] w, input bit uns,
                                          input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (w >= 2'd2) return rd;
    if (w == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // One load/store: addr_ok after aDly cycles, data_ok dDly cycles after acceptance
  task automatic txn(input bit isLoad, input logic [1:0] w, input bit uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int aDly, input int dDly,
                     input int flushAt, input int hold);
    int d;
    bit flushed;
    logic [3:0]  eStrb;
    logic [31:0] eWdata, eLoad;
    d = aDly + dDly;
    flushed = (flushAt >= 1) && (flushAt <= d);
    if (w == 2'd0)      eStrb = 4'(1 << (a % 4));
    else if (w == 2'd1) eStrb = ((a % 4) >= 2) ? 4'hC : 4'h3;
    else                eStrb = 4'hF;
    if (isLoad) eStrb = 4'h0;
    if (w == 2'd0)      eWdata = (wd & 32'hFF) * 32'h01010101;
    else if (w == 2'd1) eWdata = (wd & 32'hFFFF) * 32'h00010001;
    else                eWdata = wd;
    eLoad = expLoad(w, uns, a, rd);
    for (int c = 0; c <= d; c++) begin
      MemToRegM = isLoad && !(flushed && c > flushAt);
      MemWriteM = !isLoad && !(flushed && c > flushAt);
      MemWidthM = w; LoadUnsignedM = uns; PhyAddrM = a; WriteDataM = wd;
      ExcValidM = 1'b0; PipeEnM = 1'b0;
      FlushM = flushed && (c == flushAt);
      data_addr_ok = (c == aDly);
      data_data_ok = (c == d);
      data_rdata = (c == d) ? rd : $urandom;
      @(negedge clk);
      chk("req", 32'(data_req), 32'(c <= aDly));
      chk("stall", 32'(MemStallM), 32'(d != 0));
      chk("rd_hold", ReadDataM, refRd);
      if (c <= aDly) begin
        chk("addr", data_addr, a);
        chk("size", 32'(data_size), 32'(w));
        chk("wr", 32'(data_wr), 32'(!isLoad));
        chk("wstrb", 32'(data_wstrb), 32'(eStrb));
        chk("wdata", data_wdata, eWdata);
      end
      @(posedge clk); #1;
    end
    if (!flushed && isLoad) refRd = eLoad;
    for (int h = 0; h <= (flushed ? 0 : hold); h++) begin
      if (flushed) idle();
      else PipeEnM = (h == hold);
      FlushM = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      @(negedge clk);
      chk("post_req", 32'(data_req), 32'h0);
      chk("post_stall", 32'(MemStallM), 32'h0);
      chk("post_rd", ReadDataM, refRd);
      @(posedge clk); #1;
    end
    idle();
  endtask

  // Access that must be suppressed (misaligned or carrying an earlier exception)
  task automatic misal(input bit isLoad, input logic [1:0] w, input logic [31:0] a, input bit exc);
    int sz;
    bit m, expReq;
    sz = (w >= 2'd2) ? 4 : (1 << w);
    m = (a % sz) != 0;
    expReq = !m && !exc;
    idle();
    MemToRegM = isLoad; MemWriteM = !isLoad; MemWidthM = w; PhyAddrM = a;
    WriteDataM = $urandom; ExcValidM = exc;
    @(negedge clk);
    chk("adel", 32'(AdELM), 32'(isLoad && m && !exc));
    chk("ades", 32'(AdESM), 32'(!isLoad && m && !exc));
    chk("mis_req", 32'(data_req), 32'(expReq));
    chk("mis_stall", 32'(MemStallM), 32'(expReq));
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("mis_after", 32'(data_req | MemStallM), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit          isLoad;
    logic [1:0]  w;
    int          sz, aD, dD, fAt;
    logic [31:0] a;

    idle();
    rst = 1'b0;
    MemToRegM = 1'b1; MemWidthM = 2'b10; PhyAddrM = 32'h1000;
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    #12;
    chk("rst_req", 32'(data_req), 32'h0);
    chk("rst_stall", 32'(MemStallM), 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wstrb", 32'(data_wstrb), 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_wr", 32'(data_wr), 32'h0);
    chk("rst_rd", ReadDataM, 32'h0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;

    txn(1'b1, 2'b10, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 2, -1, 0);
    chk("tp_word", ReadDataM, 32'hDEADBEEF);
    txn(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80123456, 1, 1, -1, 1);
    chk("tp_sbyte", ReadDataM, 32'hFFFFFF80);
    txn(1'b1, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80123456, 0, 0, -1, 0);
    chk("tp_ubyte", ReadDataM, 32'h00000080);
    txn(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0000ABCD, $urandom, 0, 1, -1, 0);
    chk("tp_store_rd", ReadDataM, 32'h00000080);
    misal(1'b1, 2'b10, 32'h3002, 1'b0);
    misal(1'b0, 2'b10, 32'h3002, 1'b0);
    misal(1'b1, 2'b01, 32'h5001, 1'b0);
    misal(1'b0, 2'b11, 32'h5003, 1'b0);
    misal(1'b1, 2'b10, 32'h3001, 1'b1);
    misal(1'b0, 2'b00, 32'h3000, 1'b1);
    txn(1'b1, 2'b10, 1'b0, 32'h4000, 32'h0, $urandom, 3, 1, -1, 0);
    txn(1'b1, 2'b01, 1'b0, 32'h4002, 32'h0, 32'h8001_7FFF, 0, 0, -1, 0);
    chk("tp_shalf", ReadDataM, 32'hFFFF8001);
    txn(1'b1, 2'b10, 1'b0, 32'h5000, 32'h0, 32'h12345678, 0, 3, 1, 0);
    chk("tp_flush_rd", ReadDataM, 32'hFFFF8001);
    txn(1'b0, 2'b10, 1'b0, 32'h6000, $urandom, $urandom, 2, 1, 1, 0);
    txn(1'b1, 2'b00, 1'b0, 32'h6001, 32'h0, $urandom, 1, 2, 3, 0);

    for (int i = 0; i < 40; i++) begin
      isLoad = 1'($urandom % 2);
      w = 2'($urandom % 4);
      sz = (w >= 2'd2) ? 4 : (1 << w);
      a = $urandom & ~(32'(sz) - 32'h1);
      aD = int'($urandom % 4);
      dD = int'($urandom % 4);
      fAt = (($urandom % 4) == 0 && (aD + dD) >= 1) ? int'($urandom_range(aD + dD, 1)) : -1;
      txn(isLoad, w, 1'($urandom % 2), a, $urandom, $urandom, aD, dD, fAt, int'($urandom % 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
